// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Brief    : 4x4 matrix keypad scanner with full-frame debounce. Drives one
//            active-low column at a time, samples synchronized rows, and
//            accepts a single key press/release only after DB_FRAMES
//            consecutive identical frames.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
   parameter int SCAN_TICKS = 104_165,
   parameter int DB_FRAMES  = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_down,
   output logic       key_valid,
   output logic       key_release
);

   localparam int TIMER_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      DEB_PRESS   = 2'd1,
      PRESSED     = 2'd2,
      DEB_RELEASE = 2'd3
   } state_t;

   logic [3:0]         row_s1_q, row_s2_q;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [1:0]         col_idx_q, col_idx_d;
   logic [1:0]         acc_cnt_q, acc_cnt_d;   // 0, 1, or 2 (= two or more)
   logic [3:0]         acc_code_q, acc_code_d;
   state_t             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [3:0]         cand_q, cand_d;
   logic [3:0]         key_code_q, key_code_d;
   logic               key_down_q, key_down_d;
   logic               key_valid_q, key_valid_d;
   logic               key_release_q, key_release_d;

   logic               tick, frame_end, f_none, f_single;
   logic [2:0]         col_lows, sum;
   logic [1:0]         col_row, tot;
   logic [3:0]         frame_code, cnt_inc;

   // Two-flop synchronizer on the asynchronous row lines; idle level is all ones.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         row_s1_q <= 4'b1111;
         row_s2_q <= 4'b1111;
      end else begin
         row_s1_q <= row;
         row_s2_q <= row_s1_q;
      end
   end

   // Scan timer, column index and per-frame accumulation of low rows.
   always_comb begin
      tick       = (timer_q == TIMER_W'(SCAN_TICKS - 1));
      timer_d    = tick ? '0 : timer_q + 1'b1;
      col_idx_d  = tick ? col_idx_q + 2'd1 : col_idx_q;
      col_lows   = 3'd0;
      col_row    = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (!row_s2_q[i]) begin
            col_lows = col_lows + 3'd1;
            col_row  = 2'(i);
         end
      end
      // Running total including this column's sample, saturated at 2 (multi).
      sum        = {1'b0, acc_cnt_q} + col_lows;
      tot        = (sum >= 3'd2) ? 2'd2 : sum[1:0];
      frame_code = (acc_cnt_q == 2'd0 && col_lows == 3'd1) ? {col_row, col_idx_q} : acc_code_q;
      frame_end  = tick && (col_idx_q == 2'd3);
      f_none     = (tot == 2'd0);
      f_single   = (tot == 2'd1);
      acc_cnt_d  = acc_cnt_q;
      acc_code_d = acc_code_q;
      if (tick) begin
         if (frame_end) begin
            acc_cnt_d  = 2'd0;
            acc_code_d = 4'd0;
         end else begin
            acc_cnt_d  = tot;
            acc_code_d = frame_code;
         end
      end
   end

   // Debounce FSM: evaluated only when a frame completes.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      cand_d        = cand_q;
      key_code_d    = key_code_q;
      key_down_d    = key_down_q;
      key_valid_d   = 1'b0;
      key_release_d = 1'b0;
      cnt_inc       = (cnt_q < 4'(DB_FRAMES)) ? cnt_q + 4'd1 : cnt_q;
      if (frame_end) begin
         case (state_q)
            IDLE: begin
               if (f_single) begin
                  cand_d = frame_code;
                  cnt_d  = 4'd1;
                  if (DB_FRAMES == 1) begin
                     state_d     = PRESSED;
                     key_code_d  = frame_code;
                     key_down_d  = 1'b1;
                     key_valid_d = 1'b1;
                  end else begin
                     state_d = DEB_PRESS;
                  end
               end
            end
            DEB_PRESS: begin
               if (f_single && frame_code == cand_q) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc >= 4'(DB_FRAMES)) begin
                     state_d     = PRESSED;
                     key_code_d  = cand_q;
                     key_down_d  = 1'b1;
                     key_valid_d = 1'b1;
                  end
               end else begin
                  state_d = IDLE;
                  cnt_d   = 4'd0;
               end
            end
            PRESSED: begin
               if (f_none) begin
                  cnt_d = 4'd1;
                  if (DB_FRAMES == 1) begin
                     state_d       = IDLE;
                     key_down_d    = 1'b0;
                     key_release_d = 1'b1;
                  end else begin
                     state_d = DEB_RELEASE;
                  end
               end
            end
            DEB_RELEASE: begin
               if (f_none) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc >= 4'(DB_FRAMES)) begin
                     state_d       = IDLE;
                     key_down_d    = 1'b0;
                     key_release_d = 1'b1;
                  end
               end else begin
                  state_d = PRESSED;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State register for scan, accumulation, FSM and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         timer_q       <= '0;
         col_idx_q     <= 2'd0;
         acc_cnt_q     <= 2'd0;
         acc_code_q    <= 4'd0;
         state_q       <= IDLE;
         cnt_q         <= 4'd0;
         cand_q        <= 4'd0;
         key_code_q    <= 4'd0;
         key_down_q    <= 1'b0;
         key_valid_q   <= 1'b0;
         key_release_q <= 1'b0;
      end else begin
         timer_q       <= timer_d;
         col_idx_q     <= col_idx_d;
         acc_cnt_q     <= acc_cnt_d;
         acc_code_q    <= acc_code_d;
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         cand_q        <= cand_d;
         key_code_q    <= key_code_d;
         key_down_q    <= key_down_d;
         key_valid_q   <= key_valid_d;
         key_release_q <= key_release_d;
      end
   end

   assign col         = ~(4'b0001 << col_idx_q);
   assign key_code    = key_code_q;
   assign key_down    = key_down_q;
   assign key_valid   = key_valid_q;
   assign key_release = key_release_q;

endmodule
`default_nettype wire
